// File: rtl/l2_arbiter_rr.sv
// ============================================================================
// Module   : l2_arbiter_rr
// Brief    : N-channel arbiter between L1 cache clients and a single L2 port.
//            Build option L2_ARB_FIXED_PRIO_EN selects lowest-index priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module l2_arbiter_rr #(
  parameter int NUM_CH = 2,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           ch_read,
  input  logic [NUM_CH-1:0]           ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]    ch_addr,
  input  logic [NUM_CH*LINE_W-1:0]    ch_wdata,
  output logic [NUM_CH-1:0]           ch_resp,
  output logic [LINE_W-1:0]           ch_rdata,
  input  logic [LINE_W-1:0]           L2_rdata,
  input  logic                        L2_resp,
  output logic                        L2_read,
  output logic                        L2_write,
  output logic [ADDR_W-1:0]           L2_addr,
  output logic [LINE_W-1:0]           L2_wdata,
  output logic [$clog2(NUM_CH)-1:0]   grant_idx,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    grant_q;
  logic                rd_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;

  logic [NUM_CH-1:0]   req;
  logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
  logic [LINE_W-1:0]   wdata_arr [NUM_CH];
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    sel_d;
  logic                hit_d;

  assign req = ch_read | ch_write;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_arr[i]  = ch_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = ch_wdata[i*LINE_W +: LINE_W];
  end

  // First requester found scanning upward from rr_ptr, wrapping at NUM_CH.
  always_comb begin
    cand  = '0;
    sel_d = rr_ptr_q;
    hit_d = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_CH);
      if (!hit_d && req[cand]) begin
        hit_d = 1'b1;
        sel_d = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hit_d) begin
            grant_q <= sel_d;
            // A simultaneous read and write request is served as a write.
            wr_q    <= ch_write[sel_d];
            rd_q    <= ch_read[sel_d] & ~ch_write[sel_d];
            addr_q  <= addr_arr[sel_d];
            wdata_q <= wdata_arr[sel_d];
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (L2_resp) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef L2_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`else
            rr_ptr_q <= (grant_q == IDX_W'(NUM_CH - 1)) ? '0 : grant_q + IDX_W'(1);
`endif
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ch_resp = '0;
    if (state_q == S_BUSY && L2_resp) begin
      ch_resp[grant_q] = 1'b1;
    end
  end

  assign ch_rdata  = L2_rdata;
  assign L2_read   = rd_q;
  assign L2_write  = wr_q;
  assign L2_addr   = addr_q;
  assign L2_wdata  = wdata_q;
  assign grant_idx = grant_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire
